// File: rtl/tracking_scheduler_pkg.sv
// Shared types for the tracking-engine scheduler: FSM state encoding.
package tracking_scheduler_pkg;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'd0,
        TS_ISSUE = 2'd1,
        TS_WAIT  = 2'd2,
        TS_DONE  = 2'd3
    } ts_state_e;

endpackage

// File: rtl/tracking_scheduler_rr_priority_picker.sv
// Combinational round-robin picker: first set request after the last grant, wrapping.
module rr_priority_picker #(
    parameter int NUM_CHANNELS     = 4,
    parameter int CHANNEL_ID_WIDTH = 2
) (
    input  logic [NUM_CHANNELS-1:0]     req,
    input  logic [CHANNEL_ID_WIDTH-1:0] last,
    output logic                        valid,
    output logic [CHANNEL_ID_WIDTH-1:0] idx
);

    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        // Scan farthest to nearest so the nearest hit after 'last' overwrites the rest.
        for (int k = NUM_CHANNELS; k >= 1; k--) begin
            cand = (int'(last) + k) % NUM_CHANNELS;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = CHANNEL_ID_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/tracking_scheduler.sv
// Time-shares one tracking engine among channel histories: latches requests,
// grants round-robin, tracks the tagged job and reports completion or abort.
module tracking_scheduler
    import tracking_scheduler_pkg::*;
#(
    parameter int NUM_CHANNELS     = 4,
    parameter int CHANNEL_ID_WIDTH = 2,
    parameter int TIMEOUT_CYCLES   = 1023
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CHANNELS-1:0]     req_valid,
    output logic                        eng_start,
    output logic [CHANNEL_ID_WIDTH-1:0] eng_tag,
    input  logic                        eng_starting,
    input  logic                        eng_done,
    input  logic [CHANNEL_ID_WIDTH-1:0] eng_done_tag,
    output logic [CHANNEL_ID_WIDTH-1:0] ch_select,
    output logic [NUM_CHANNELS-1:0]     tracking_ready,
    output logic [NUM_CHANNELS-1:0]     overrun,
    output logic                        tag_error,
    output logic                        timeout,
    output logic                        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_CHANNELS-1:0] ONE = NUM_CHANNELS'(1);

    ts_state_e                     state, state_nxt;
    logic [NUM_CHANNELS-1:0]       pending;
    logic [NUM_CHANNELS-1:0]       grant_clear;
    logic [CHANNEL_ID_WIDTH-1:0]   cur_tag;
    logic [CHANNEL_ID_WIDTH-1:0]   last_grant;
    logic [TW-1:0]                 to_cnt;
    logic                          pick_valid;
    logic [CHANNEL_ID_WIDTH-1:0]   pick_idx;
    logic                          grant;
    logic                          done_hit;
    logic                          expired;

    rr_priority_picker #(
        .NUM_CHANNELS     (NUM_CHANNELS),
        .CHANNEL_ID_WIDTH (CHANNEL_ID_WIDTH)
    ) u_picker (
        .req   (pending),
        .last  (last_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign done_hit    = eng_done && (eng_done_tag == cur_tag);
    assign expired     = (to_cnt == TO_LAST);
    assign grant_clear = grant ? (ONE << pick_idx) : '0;
    assign busy        = (state != TS_IDLE);
    assign ch_select   = cur_tag;
    assign eng_tag     = cur_tag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= TS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion is checked before expiry so a done on the last allowed cycle still counts.
    always_comb begin
        state_nxt      = state;
        grant          = 1'b0;
        eng_start      = 1'b0;
        tag_error      = 1'b0;
        timeout        = 1'b0;
        tracking_ready = '0;
        case (state)
            TS_IDLE: begin
                if (pick_valid) begin
                    grant     = 1'b1;
                    state_nxt = TS_ISSUE;
                end
            end
            TS_ISSUE: begin
                eng_start = 1'b1;
                if (expired) begin
                    timeout   = 1'b1;
                    state_nxt = TS_IDLE;
                end else if (eng_starting) begin
                    state_nxt = TS_WAIT;
                end
            end
            TS_WAIT: begin
                tag_error = eng_done && !done_hit;
                if (done_hit) begin
                    state_nxt = TS_DONE;
                end else if (expired) begin
                    timeout   = 1'b1;
                    state_nxt = TS_IDLE;
                end
            end
            TS_DONE: begin
                tracking_ready = ONE << cur_tag;
                state_nxt      = TS_IDLE;
            end
            default: state_nxt = TS_IDLE;
        endcase
    end

    // A request landing on its own grant consumes nothing already queued, so it is not an overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            overrun    <= '0;
            cur_tag    <= '0;
            last_grant <= CHANNEL_ID_WIDTH'(NUM_CHANNELS - 1);
            to_cnt     <= '0;
        end else begin
            pending <= (pending & ~grant_clear) | req_valid;
            overrun <= req_valid & pending & ~grant_clear;
            if (grant) begin
                cur_tag <= pick_idx;
                to_cnt  <= '0;
            end else if (state == TS_ISSUE || state == TS_WAIT) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (state == TS_DONE || timeout) begin
                last_grant <= cur_tag;
            end
        end
    end

endmodule

// File: tb/tb_tracking_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a job-level model.
module tb_tracking_scheduler;

    localparam int N = 4;
    localparam int W = 2;
    localparam int T = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_valid;
    logic         eng_start;
    logic [W-1:0] eng_tag;
    logic         eng_starting;
    logic         eng_done;
    logic [W-1:0] eng_done_tag;
    logic [W-1:0] ch_select;
    logic [N-1:0] tracking_ready;
    logic [N-1:0] overrun;
    logic         tag_error;
    logic         timeout;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // Job-level model: a queue of pending channels, and at most one job with its age.
    bit           m_pend[N];
    logic [N-1:0] m_ovr;
    int           m_last, m_job, m_age, m_sel;
    bit           m_active, m_started, m_finishing;
    int           plan_dur;

    tracking_scheduler #(
        .NUM_CHANNELS     (N),
        .CHANNEL_ID_WIDTH (W),
        .TIMEOUT_CYCLES   (T)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .eng_start      (eng_start),
        .eng_tag        (eng_tag),
        .eng_starting   (eng_starting),
        .eng_done       (eng_done),
        .eng_done_tag   (eng_done_tag),
        .ch_select      (ch_select),
        .tracking_ready (tracking_ready),
        .overrun        (overrun),
        .tag_error      (tag_error),
        .timeout        (timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_ovr       = '0;
        m_last      = N - 1;
        m_job       = 0;
        m_age       = 0;
        m_sel       = 0;
        m_active    = 1'b0;
        m_started   = 1'b0;
        m_finishing = 1'b0;
        plan_dur    = T + 5;
    endfunction

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic cycle(input logic [N-1:0] rq, input logic st, input logic dn, input logic [W-1:0] dt);
        bit svc, wt, hit;
        int pick;
        @(posedge clk);
        #1;
        req_valid    = rq;
        eng_starting = st;
        eng_done     = dn;
        eng_done_tag = dt;
        #1;
        svc = m_active && !m_finishing;
        wt  = svc && m_started;
        hit = wt && dn && (int'(dt) == m_job);
        chk("busy", busy, m_active);
        chk("eng_start", eng_start, svc && !m_started);
        chk("eng_tag", eng_tag, m_sel);
        chk("ch_select", ch_select, m_sel);
        chk("tracking_ready", tracking_ready, m_finishing ? (1 << m_job) : 0);
        chk("overrun", overrun, m_ovr);
        chk("tag_error", tag_error, wt && dn && !hit);
        chk("timeout", timeout, svc && (m_age == T) && !hit);

        pick = -1;
        if (!m_active) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_pend[c] && pick < 0) pick = c;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_ovr[i]  = rq[i] && m_pend[i] && (i != pick);
            m_pend[i] = (m_pend[i] && (i != pick)) || rq[i];
        end
        if (pick >= 0) begin
            m_active    = 1'b1;
            m_job       = pick;
            m_sel       = pick;
            m_started   = 1'b0;
            m_finishing = 1'b0;
            m_age       = 1;
            plan_dur    = $urandom_range(3, T + 4);
        end else if (m_finishing) begin
            m_active    = 1'b0;
            m_finishing = 1'b0;
            m_last      = m_job;
        end else if (m_active) begin
            if (hit) begin
                m_finishing = 1'b1;
            end else if (m_age == T) begin
                m_active = 1'b0;
                m_last   = m_job;
            end else begin
                if (!m_started && st) m_started = 1'b1;
                m_age++;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset        = 1'b0;
        req_valid    = '0;
        eng_starting = 1'b0;
        eng_done     = 1'b0;
        eng_done_tag = '0;
        model_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_ch_select", ch_select, 0);
        chk("rst_tracking_ready", tracking_ready, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_tag_error", tag_error, 0);
        chk("rst_timeout", timeout, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Reset asserted between clock edges; control outputs must drop without waiting for a clock.
    task automatic async_reset_now();
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_eng_start", eng_start, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ch_select", ch_select, 0);
        @(negedge clk);
        req_valid    = '0;
        eng_starting = 1'b0;
        eng_done     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits (bounded) for the next start request, accepts it, and completes the job.
    task automatic serve_next(output int tag);
        bit got;
        got = 1'b0;
        tag = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            if (m_active && !m_finishing && !m_started) begin
                cycle('0, 1'b1, 1'b0, '0);
                tag = eng_tag;
                got = 1'b1;
            end else begin
                cycle('0, 1'b0, 1'b0, '0);
            end
        end
        if (!got) begin
            chk("serve_start_seen", 0, 1);
        end else begin
            repeat (3) cycle('0, 1'b0, 1'b0, '0);
            cycle('0, 1'b0, 1'b1, W'(m_job));
            cycle('0, 1'b0, 1'b0, '0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int t;
        int to_at;
        bit ready_seen;
        logic [N-1:0] rq;
        logic st, dn;
        logic [W-1:0] dt;

        reset        = 1'b0;
        req_valid    = '0;
        eng_starting = 1'b0;
        eng_done     = 1'b0;
        eng_done_tag = '0;
        model_reset();
        #2;
        chk("init_busy", busy, 0);
        chk("init_eng_start", eng_start, 0);

        // Single request: start from cycle 2, ready in cycle 11 only.
        apply_reset();
        cycle(4'b0001, 1'b0, 1'b0, '0);           // c0
        cycle('0, 1'b0, 1'b0, '0);                // c1
        chk("single_c1_start", eng_start, 0);
        cycle('0, 1'b0, 1'b1, 2'd1);              // c2: stray done outside WAIT
        chk("single_c2_start", eng_start, 1);
        chk("single_c2_tag", eng_tag, 0);
        chk("single_c2_no_tagerr", tag_error, 0);
        cycle('0, 1'b1, 1'b0, '0);                // c3
        cycle('0, 1'b0, 1'b0, '0);                // c4
        chk("single_c4_start_low", eng_start, 0);
        repeat (5) cycle('0, 1'b0, 1'b0, '0);     // c5..c9
        cycle('0, 1'b0, 1'b1, 2'd0);              // c10
        chk("single_c10_ready", tracking_ready, 0);
        cycle('0, 1'b0, 1'b0, '0);                // c11
        chk("single_c11_ready", tracking_ready, 1);
        cycle('0, 1'b0, 1'b0, '0);                // c12
        chk("single_c12_ready", tracking_ready, 0);

        // Round-robin order.
        apply_reset();
        cycle(4'b1011, 1'b0, 1'b0, '0);
        serve_next(t); chk("rr_grant_a", t, 0);
        serve_next(t); chk("rr_grant_b", t, 1);
        serve_next(t); chk("rr_grant_c", t, 3);
        cycle(4'b1001, 1'b0, 1'b0, '0);
        serve_next(t); chk("rr_grant_d", t, 0);
        serve_next(t); chk("rr_grant_e", t, 3);

        // Overrun / merge on channel 2 while channel 0 is busy.
        apply_reset();
        cycle(4'b0001, 1'b0, 1'b0, '0);           // c0
        cycle('0, 1'b0, 1'b0, '0);                // c1
        cycle(4'b0100, 1'b0, 1'b0, '0);           // c2
        cycle('0, 1'b1, 1'b0, '0);                // c3
        chk("ovr_c3", overrun, 0);
        cycle('0, 1'b0, 1'b0, '0);                // c4
        cycle(4'b0100, 1'b0, 1'b0, '0);           // c5
        cycle('0, 1'b0, 1'b0, '0);                // c6
        chk("ovr_c6", overrun, 4'b0100);
        cycle('0, 1'b0, 1'b1, 2'd0);              // c7
        chk("ovr_c7", overrun, 0);
        cycle('0, 1'b0, 1'b0, '0);                // c8 DONE
        serve_next(t); chk("ovr_served", t, 2);
        repeat (5) cycle('0, 1'b0, 1'b0, '0);
        chk("ovr_served_once", busy, 0);

        // Request for the channel in service.
        apply_reset();
        cycle(4'b0010, 1'b0, 1'b0, '0);           // c0
        cycle('0, 1'b0, 1'b0, '0);                // c1
        cycle('0, 1'b1, 1'b0, '0);                // c2
        cycle('0, 1'b0, 1'b0, '0);                // c3
        cycle(4'b0010, 1'b0, 1'b0, '0);           // c4
        cycle('0, 1'b0, 1'b1, 2'd1);              // c5
        chk("own_no_overrun", overrun, 0);
        cycle('0, 1'b0, 1'b0, '0);                // c6
        chk("own_ready", tracking_ready, 4'b0010);
        serve_next(t); chk("own_reserved", t, 1);

        // Tag mismatch, then timeout 20 cycles after the grant in c1.
        apply_reset();
        cycle(4'b0001, 1'b0, 1'b0, '0);           // c0
        cycle('0, 1'b0, 1'b0, '0);                // c1
        cycle('0, 1'b0, 1'b0, '0);                // c2
        cycle('0, 1'b1, 1'b0, '0);                // c3
        cycle('0, 1'b0, 1'b0, '0);                // c4
        cycle('0, 1'b0, 1'b1, 2'd3);              // c5
        chk("tagerr_c5", tag_error, 1);
        cycle('0, 1'b0, 1'b0, '0);                // c6
        chk("tagerr_c6", tag_error, 0);
        to_at = -1;
        ready_seen = 1'b0;
        for (int c = 7; c <= 25; c++) begin
            cycle('0, 1'b0, 1'b0, '0);
            if (timeout && to_at < 0) to_at = c;
            if (tracking_ready != '0) ready_seen = 1'b1;
        end
        chk("timeout_cycle", to_at, 21);
        chk("timeout_no_ready", ready_seen, 0);
        chk("timeout_busy_low", busy, 0);

        // Correct done on the final allowed cycle beats the timeout.
        apply_reset();
        cycle(4'b0001, 1'b0, 1'b0, '0);           // c0
        cycle('0, 1'b0, 1'b0, '0);                // c1
        cycle('0, 1'b0, 1'b0, '0);                // c2
        cycle('0, 1'b1, 1'b0, '0);                // c3
        for (int c = 4; c <= 20; c++) cycle('0, 1'b0, 1'b0, '0);
        cycle('0, 1'b0, 1'b1, 2'd0);              // c21
        chk("race_no_timeout", timeout, 0);
        cycle('0, 1'b0, 1'b0, '0);                // c22
        chk("race_ready", tracking_ready, 1);

        // Reset while the start request is held.
        apply_reset();
        cycle(4'b0001, 1'b0, 1'b0, '0);
        cycle('0, 1'b0, 1'b0, '0);
        cycle('0, 1'b0, 1'b0, '0);
        chk("issue_before_rst", eng_start, 1);
        async_reset_now();

        // Reset mid-WAIT with channel 2 pending: pending is lost, channel 0 wins next.
        cycle(4'b0010, 1'b0, 1'b0, '0);
        cycle('0, 1'b0, 1'b0, '0);
        cycle('0, 1'b1, 1'b0, '0);
        cycle(4'b0100, 1'b0, 1'b0, '0);
        cycle('0, 1'b0, 1'b0, '0);
        chk("wait_before_rst", busy, 1);
        async_reset_now();
        repeat (4) cycle('0, 1'b0, 1'b0, '0);
        chk("rst_pending_lost", busy, 0);
        cycle(4'b1111, 1'b0, 1'b0, '0);
        serve_next(t); chk("rst_first_grant", t, 0);

        // Randomized traffic and engine behaviour.
        for (int it = 0; it < 3000; it++) begin
            bit svc, wt;
            svc = m_active && !m_finishing;
            wt  = svc && m_started;
            for (int i = 0; i < N; i++) rq[i] = ($urandom % 6 == 0);
            st = (svc && !m_started) ? ($urandom % 2 == 1) : 1'b0;
            dn = 1'b0;
            dt = '0;
            if (wt) begin
                if (m_age >= plan_dur) begin
                    dn = 1'b1;
                    dt = W'(m_job);
                end else if ($urandom % 12 == 0) begin
                    dn = 1'b1;
                    dt = W'((m_job + 1 + $urandom % 3) % N);
                end
            end else begin
                dn = ($urandom % 10 == 0);
                dt = W'($urandom % N);
            end
            cycle(rq, st, dn, dt);
            if (it == 1500) async_reset_now();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
